// File: rtl/percent_to_quad.sv
// Percent-to-quad: successive-approximation sqrt of p<<8 picks k, then emits centered 4k x 3k corners.
// Latency 9 clocks start-to-done, fixed; start is ignored while busy, with no queuing.
module percent_to_quad (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] percent_kept,
    output logic       busy,
    output logic       done,
    output logic [7:0] scale_k,
    output logic [9:0] x1,
    output logic [9:0] x2,
    output logic [9:0] x3,
    output logic [9:0] x4,
    output logic [8:0] y1,
    output logic [8:0] y2,
    output logic [8:0] y3,
    output logic [8:0] y4
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        CORNERS
    } state_t;

    state_t      state;
    logic [6:0]  p_reg;
    logic [7:0]  k_acc;
    logic [2:0]  bit_idx;

    logic [6:0]  p_clamped;
    logic [7:0]  trial;
    logic [15:0] trial_sq;
    logic [15:0] target;
    logic        accept;

    logic [10:0] k_w;
    logic [10:0] two_k;
    logic [10:0] three_k;
    logic [10:0] half_3k;
    logic [10:0] xl_w;
    logic [10:0] xr_w;
    logic [10:0] yt_w;
    logic [10:0] yb_w;
    logic [9:0]  xl;
    logic [9:0]  xr;
    logic [8:0]  yt;
    logic [8:0]  yb;

    function automatic logic [9:0] clamp_x(input logic [10:0] v);
        clamp_x = (v > 11'd639) ? 10'd639 : v[9:0];
    endfunction

    function automatic logic [8:0] clamp_y(input logic [10:0] v);
        clamp_y = (v > 11'd479) ? 9'd479 : v[8:0];
    endfunction

    always_comb begin
        p_clamped = (percent_kept > 7'd100) ? 7'd100 : percent_kept;
        trial     = k_acc | (8'd1 << bit_idx);
        trial_sq  = {8'd0, trial} * {8'd0, trial};
        target    = {1'b0, p_reg, 8'd0};
        accept    = (trial <= 8'd160) && (trial_sq <= target);
    end

    // Height split: the top half gets floor(3k/2), the bottom gets the remainder.
    always_comb begin
        k_w     = {3'd0, k_acc};
        two_k   = k_w << 1;
        three_k = k_w * 11'd3;
        half_3k = three_k >> 1;
        xl_w    = 11'd320 - two_k;
        xr_w    = 11'd320 + two_k;
        yt_w    = 11'd240 - half_3k;
        yb_w    = 11'd240 + three_k - half_3k;
        xl      = clamp_x(xl_w);
        xr      = clamp_x(xr_w);
        yt      = clamp_y(yt_w);
        yb      = clamp_y(yb_w);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            p_reg   <= 7'd0;
            k_acc   <= 8'd0;
            bit_idx <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            scale_k <= 8'd160;
            x1      <= 10'd0;
            y1      <= 9'd0;
            x2      <= 10'd639;
            y2      <= 9'd0;
            x3      <= 10'd639;
            y3      <= 9'd479;
            x4      <= 10'd0;
            y4      <= 9'd479;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_reg   <= p_clamped;
                        k_acc   <= 8'd0;
                        bit_idx <= 3'd7;
                        busy    <= 1'b1;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (accept) begin
                        k_acc <= trial;
                    end
                    if (bit_idx == 3'd0) begin
                        state <= CORNERS;
                    end else begin
                        bit_idx <= bit_idx - 3'd1;
                    end
                end
                CORNERS: begin
                    scale_k <= k_acc;
                    x1      <= xl;
                    y1      <= yt;
                    x2      <= xr;
                    y2      <= yt;
                    x3      <= xr;
                    y3      <= yb;
                    x4      <= xl;
                    y4      <= yb;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_percent_to_quad.sv
// Bench for percent_to_quad: directed table, handshake/reset sequences, random p against a model.
module tb_percent_to_quad;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [6:0] percent_kept;
    logic       busy;
    logic       done;
    logic [7:0] scale_k;
    logic [9:0] x1, x2, x3, x4;
    logic [8:0] y1, y2, y3, y4;

    int checks;
    int failures;

    percent_to_quad dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .percent_kept (percent_kept),
        .busy         (busy),
        .done         (done),
        .scale_k      (scale_k),
        .x1           (x1),
        .x2           (x2),
        .x3           (x3),
        .x4           (x4),
        .y1           (y1),
        .y2           (y2),
        .y3           (y3),
        .y4           (y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int k;
        int ex1;
        int ex2;
        int ey1;
        int ey3;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Largest k with k*k <= 256*p, searched upward, limited to 160.
    function automatic int model_k(input int p);
        int pc;
        int k;
        pc = (p > 100) ? 100 : p;
        k = 0;
        while (k < 160 && (k + 1) * (k + 1) <= 256 * pc) k++;
        return k;
    endfunction

    task automatic check_model(input string tag, input int p);
        int k, xl, xr, h, yt, yb;
        k  = model_k(p);
        xl = 320 - 2 * k;
        xr = (320 + 2 * k > 639) ? 639 : 320 + 2 * k;
        h  = (3 * k) / 2;
        yt = 240 - h;
        yb = (240 + 3 * k - h > 479) ? 479 : 240 + 3 * k - h;
        check({tag, " k"},  int'(scale_k), k);
        check({tag, " x1"}, int'(x1), xl);
        check({tag, " y1"}, int'(y1), yt);
        check({tag, " x2"}, int'(x2), xr);
        check({tag, " y2"}, int'(y2), yt);
        check({tag, " x3"}, int'(x3), xr);
        check({tag, " y3"}, int'(y3), yb);
        check({tag, " x4"}, int'(x4), xl);
        check({tag, " y4"}, int'(y4), yb);
        check({tag, " kept<=p"}, int'(int'(scale_k) * int'(scale_k) <= 256 * ((p > 100) ? 100 : p)), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " k"},  int'(scale_k), 160);
        check({tag, " x1"}, int'(x1), 0);
        check({tag, " y1"}, int'(y1), 0);
        check({tag, " x2"}, int'(x2), 639);
        check({tag, " y2"}, int'(y2), 0);
        check({tag, " x3"}, int'(x3), 639);
        check({tag, " y3"}, int'(y3), 479);
        check({tag, " x4"}, int'(x4), 0);
        check({tag, " y4"}, int'(y4), 479);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge E0.
    task automatic pulse_start(input int p);
        percent_kept = 7'(p);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts edges after E0; returns at the negedge where done is seen (or the bound expires).
    task automatic wait_done(input int start_lat, output int lat);
        lat = start_lat;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy during search", int'(busy), 1);
        end
    endtask

    initial begin
        int lat;
        int p;
        int seen_done;
        int prev_k;

        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        start = 1'b0;
        percent_kept = 7'd0;

        vecs[0] = '{p: 25,  k: 80,  ex1: 160, ex2: 480, ey1: 120, ey3: 360};
        vecs[1] = '{p: 100, k: 160, ex1: 0,   ex2: 639, ey1: 0,   ey3: 479};
        vecs[2] = '{p: 127, k: 160, ex1: 0,   ex2: 639, ey1: 0,   ey3: 479};
        vecs[3] = '{p: 0,   k: 0,   ex1: 320, ex2: 320, ey1: 240, ey3: 240};
        vecs[4] = '{p: 50,  k: 113, ex1: 94,  ex2: 546, ey1: 71,  ey3: 410};
        vecs[5] = '{p: 1,   k: 16,  ex1: 288, ex2: 352, ey1: 216, ey3: 264};

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < 6; i++) begin
            pulse_start(vecs[i].p);
            wait_done(0, lat);
            check($sformatf("vec%0d latency", i), lat, 9);
            check($sformatf("vec%0d k", i),  int'(scale_k), vecs[i].k);
            check($sformatf("vec%0d x1", i), int'(x1), vecs[i].ex1);
            check($sformatf("vec%0d x2", i), int'(x2), vecs[i].ex2);
            check($sformatf("vec%0d y1", i), int'(y1), vecs[i].ey1);
            check($sformatf("vec%0d y3", i), int'(y3), vecs[i].ey3);
            check_model($sformatf("vec%0d", i), vecs[i].p);
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), int'(done), 0);
            check($sformatf("vec%0d busy after", i), int'(busy), 0);
        end

        // Second start at E4 must be ignored; outputs must not move mid-search.
        prev_k = vecs[5].k;
        pulse_start(1);
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        check("ignored: busy", int'(busy), 1);
        check("ignored: k stable in search", int'(scale_k), prev_k);
        percent_kept = 7'd25;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        wait_done(lat, lat);
        check("ignored: latency", lat, 9);
        check("ignored: k", int'(scale_k), 16);
        check("ignored: x1", int'(x1), 288);
        check("ignored: y3", int'(y3), 264);

        // Start on the done cycle is accepted.
        pulse_start(25);
        wait_done(0, lat);
        check("done-cycle start: latency", lat, 9);
        check("done-cycle start: k", int'(scale_k), 80);
        check_model("done-cycle start", 25);

        // Reset lands on E5 of a p=50 search.
        @(negedge clk);
        pulse_start(50);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 0;
        repeat (15) begin
            if (done) seen_done = 1;
            @(negedge clk);
        end
        check("abort: no done", seen_done, 0);
        check_reset_vals("abort");
        pulse_start(50);
        wait_done(0, lat);
        check("after abort: latency", lat, 9);
        check("after abort: k", int'(scale_k), 113);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(0, 127));
            pulse_start(p);
            wait_done(0, lat);
            check($sformatf("rand%0d p=%0d latency", i, p), lat, 9);
            check_model($sformatf("rand%0d p=%0d", i, p), p);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/percent_to_quad.md
# percent_to_quad

Inverse of the keystone-loss calculator. Given a requested percentage of frame pixels to keep, it computes the four corners of a centered 4:3 rectangle covering that fraction of the 640x480 frame. The search is an iterative 8-step successive-approximation square root. Corners are emitted in the same quad ordering the loss calculator consumes, so the two blocks can be cascaded: 1 = top-left, 2 = top-right, 3 = bottom-right, 4 = bottom-left.

## Interface
Parameters:
- none (frame fixed at 640x480, center (320,240))

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- start  in  1  one-cycle request strobe; sampled only in IDLE
- percent_kept  in  7  requested percent, 0..127; values >100 clamp to 100
- busy  out  1  high from the edge accepting start through the edge before done
- done  out  1  one-cycle pulse; corner outputs valid and stable from this cycle on
- scale_k  out  8  selected scale k; rectangle is 4k wide, 3k high
- x1, x2, x3, x4  out  10 each  corner x coordinates
- y1, y2, y3, y4  out  9 each  corner y coordinates

## Operation
- States:
  - IDLE: waits for start. On start, latches p = min(percent_kept, 100), clears k_acc, sets bit index b = 7, busy = 1, then goes to SEARCH.
  - SEARCH: runs 8 edges, b = 7 down to 0.
    - trial = k_acc | (1<<b).
    - Accept trial (k_acc <= trial) iff trial <= 160 and trial*trial <= p<<8.
    - Comparison is unsigned 16-bit: trial*trial is 8x8 -> 16 bits; p<<8 is 15 bits, zero-extended.
    - After b = 0, goes to CORNERS.
  - CORNERS: one edge.
    - Registers all outputs from k = k_acc.
    - Pulses done = 1, drops busy, returns to IDLE.
- Resulting k = floor(16*sqrt(p)), capped at 160. Kept fraction is k^2/256 percent, which is always <= p.
- Corner arithmetic, unsigned, 11-bit intermediates:
  - xl = 320 - 2k; xr = min(320 + 2k, 639)
  - yt = 240 - floor(3k/2); yb = min(240 + 3k - floor(3k/2), 479)
  - (x1,y1) = (xl,yt); (x2,y2) = (xr,yt); (x3,y3) = (xr,yb); (x4,y4) = (xl,yb)
- Outputs hold their last values until the next CORNERS edge. They never change during SEARCH.
- start while busy: ignored, with no queuing.
- start on the same cycle done is high: accepted, because the FSM is already in IDLE.
- Reset values, also forced by reset_n = 0 mid-search:
  - state IDLE, busy = 0, done = 0, scale_k = 160
  - x1 = 0, y1 = 0, x2 = 639, y2 = 0, x3 = 639, y3 = 479, x4 = 0, y4 = 479 (full frame, 0% lost)
  - A search aborted by reset produces no done pulse.

## Timing
- Edge E0 accepts start. busy is high after E0.
- Edges E1..E8 perform the search on bits 7..0.
- Edge E9 loads the outputs, sets done = 1 and busy = 0.
- done is high for exactly the cycle following E9. Start-to-done latency is 9 clocks, fixed and independent of p.
- Minimum start-to-start spacing is 10 clocks (E0 to E9 inclusive).
- One 8x8 multiply plus one compare per SEARCH cycle. No multicycle paths.

## Test plan
- Reset, then idle 5 cycles:
  - busy = 0, done = 0, scale_k = 160
  - corners (0,0), (639,0), (639,479), (0,479)
- start with p = 25:
  - done exactly 9 clocks later
  - k = 80; x1 = 160, x2 = 480, y1 = 120, y3 = 360
- Clamp and extremes:
  - p = 100 and p = 127 both give k = 160 and the full-frame corners, with clamped xr = 639, yb = 479.
  - p = 0 gives k = 0 and all corners at (320,240).
- Rounding case: p = 50 gives k = 113, x1 = 94, x2 = 546, y1 = 71, y3 = 410. The kept fraction k^2/256 = 49.88% is never above p.
- Handshake:
  - p = 1 gives k = 16, x1 = 288, x2 = 352, y1 = 216, y3 = 264.
  - A second start with p = 25 at E4 is ignored; the outputs still match p = 1.
  - start on the done cycle with p = 25 yields a second done 9 clocks later with k = 80.
- Reset mid-operation:
  - Assert reset_n = 0 at E5 of a p = 50 search.
  - No done pulse follows; outputs return to the full-frame reset values.
  - A following start with p = 50 completes normally with k = 113.
